muldiv_hilo_ctrl: RTL and testbench

Sequencing controller for the EX-stage multiply/divide resources and the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, drives the pipelined multiplier and the iterative divider through their start/ready handshake, and raises a stall request until the result is committed to HI/LO. It also owns HI/LO, which it presents to EX for MFHI/MFLO.

---
 rtl/muldiv_hilo_ctrl_pkg.sv | 31 +++
 rtl/muldiv_hilo_ctrl_hilo_reg.sv | 24 ++
 rtl/muldiv_hilo_ctrl.sv | 169 ++++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared encodings for the mul/div HI/LO sequencing controller.
// Holds the EX op codes, the FSM state encoding and the op classification helper.
package muldiv_hilo_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_RUN  = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  // Ops that occupy the multiplier or divider and therefore stall EX at issue.
  function automatic logic is_long_op(input op_e op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_long_op = 1'b1;
      default:                            is_long_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_hilo_reg.sv
// Architectural HI/LO register pair with independent write enables.
module hilo_reg (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hi_wdata,
  input  logic [31:0] lo_wdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // HI/LO storage; each half written only when its enable is set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else begin
      if (hi_we) hi <= hi_wdata;
      if (lo_we) lo <= lo_wdata;
    end
  end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Sequences the external multiplier/divider for EX, stalls until commit,
// and owns the HI/LO pair read by MFHI/MFLO.
module muldiv_hilo_ctrl
  import muldiv_hilo_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        ex_advance,
  input  logic        annul,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        stallreq,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] MUL_CNT_INIT = 3'(MUL_LAT - 1);

  state_e      state_r, state_s;
  logic [2:0]  cnt_r, cnt_s;
  op_e         op_s;
  logic        load_mul_s, load_div_s;
  logic        hi_we_s, lo_we_s;
  logic [31:0] hi_wdata_s, lo_wdata_s;

  assign op_s = op_e'(op_code);
  assign busy = (state_r != ST_IDLE);

  // State, countdown and operand registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 3'd0;
      mul_signed <= 1'b0;
      mul_a      <= 32'd0;
      mul_b      <= 32'd0;
      div_signed <= 1'b0;
      div_opa    <= 32'd0;
      div_opb    <= 32'd0;
      div_start  <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      // Start is level-held for the whole divide so the divider sees it the cycle after issue.
      div_start <= (state_s == ST_DIV_RUN);
      if (load_mul_s) begin
        mul_signed <= (op_s == OP_MULT);
        mul_a      <= src_a;
        mul_b      <= src_b;
      end
      if (load_div_s) begin
        div_signed <= (op_s == OP_DIV);
        div_opa    <= src_a;
        div_opb    <= src_b;
      end
    end
  end

  // Next-state, HI/LO write selection, stall and abort generation.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    load_mul_s = 1'b0;
    load_div_s = 1'b0;
    hi_we_s    = 1'b0;
    lo_we_s    = 1'b0;
    hi_wdata_s = 32'd0;
    lo_wdata_s = 32'd0;
    stallreq   = 1'b0;
    div_annul  = 1'b0;
    if (annul) begin
      // Flush beats every transition; nothing is committed this cycle.
      state_s   = ST_IDLE;
      cnt_s     = 3'd0;
      div_annul = (state_r == ST_DIV_RUN);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (op_valid) begin
            stallreq = is_long_op(op_s);
            case (op_s)
              OP_MULT, OP_MULTU: begin
                load_mul_s = 1'b1;
                cnt_s      = MUL_CNT_INIT;
                state_s    = ST_MUL_WAIT;
              end
              OP_DIV, OP_DIVU: begin
                load_div_s = 1'b1;
                state_s    = ST_DIV_RUN;
              end
              OP_MTHI: begin
                hi_we_s    = 1'b1;
                hi_wdata_s = src_a;
              end
              OP_MTLO: begin
                lo_we_s    = 1'b1;
                lo_wdata_s = src_a;
              end
              default: begin
                state_s = ST_IDLE;
              end
            endcase
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_MUL_WAIT: begin
          if (cnt_r == 3'd0) begin
            hi_we_s    = 1'b1;
            lo_we_s    = 1'b1;
            hi_wdata_s = mul_result[63:32];
            lo_wdata_s = mul_result[31:0];
            state_s    = ST_DONE;
          end else begin
            stallreq = 1'b1;
            cnt_s    = cnt_r - 3'd1;
          end
        end
        ST_DIV_RUN: begin
          if (div_ready) begin
            hi_we_s    = 1'b1;
            lo_we_s    = 1'b1;
            hi_wdata_s = div_result[63:32];
            lo_wdata_s = div_result[31:0];
            state_s    = ST_DONE;
          end else begin
            stallreq = 1'b1;
          end
        end
        ST_DONE: begin
          // op_valid is ignored here so a stalled EX cannot re-issue its op.
          if (ex_advance) state_s = ST_IDLE;
          else            state_s = ST_DONE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  hilo_reg u_hilo_reg (
    .clk      (clk),
    .resetn   (resetn),
    .hi_we    (hi_we_s),
    .lo_we    (lo_we_s),
    .hi_wdata (hi_wdata_s),
    .lo_wdata (lo_wdata_s),
    .hi       (hi),
    .lo       (lo)
  );

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Scoreboard bench for muldiv_hilo_ctrl with behavioural multiplier/divider models.
module tb_muldiv_hilo_ctrl;
  import muldiv_hilo_ctrl_pkg::*;

  localparam int DIV_DELAY = 33;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = 3'd0;
  logic [31:0] src_a = 32'd0, src_b = 32'd0;
  logic        ex_advance = 1'b1;
  logic        annul = 1'b0;
  logic        mul_signed, div_start, div_signed, div_annul, div_ready;
  logic [31:0] mul_a, mul_b, div_opa, div_opb, hi, lo;
  logic [63:0] mul_result, div_result;
  logic        stallreq, busy;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [63:0] sb_q[$];
  int          dcnt;

  muldiv_hilo_ctrl #(.MUL_LAT(2)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_code(op_code),
    .src_a(src_a), .src_b(src_b), .ex_advance(ex_advance), .annul(annul),
    .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_opa(div_opa), .div_opb(div_opb),
    .div_annul(div_annul), .div_ready(div_ready), .div_result(div_result),
    .stallreq(stallreq), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Multiplier model: product available combinationally from the registered operands.
  logic signed [63:0] sa, sb;
  assign sa = {{32{mul_a[31]}}, mul_a};
  assign sb = {{32{mul_b[31]}}, mul_b};
  assign mul_result = mul_signed ? 64'(sa * sb) : 64'({32'd0, mul_a} * {32'd0, mul_b});

  // Divider model: ready DIV_DELAY cycles after start rises, cleared when start drops.
  always @(posedge clk or negedge resetn) begin
    if (!resetn)         dcnt <= 0;
    else if (!div_start) dcnt <= 0;
    else                 dcnt <= dcnt + 1;
  end
  assign div_ready = div_start && (dcnt == DIV_DELAY);
  assign div_result = (div_opb == 32'd0) ? 64'd0 :
                      div_signed ? {32'($signed(div_opa) % $signed(div_opb)),
                                    32'($signed(div_opa) / $signed(div_opb))}
                                 : {div_opa % div_opb, div_opa / div_opb};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, count stall cycles, then compare HI/LO one cycle after commit.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_stall, input logic [63:0] exp_hilo,
                        output bit saw_start);
    int n;
    sb_q.push_back(exp_hilo);
    op_valid = 1'b1; op_code = op; src_a = a; src_b = b;
    #1;
    n = 0; saw_start = 1'b0;
    while (stallreq && n < 200) begin
      n++;
      if (div_start) saw_start = 1'b1;
      tick();
      op_valid = 1'b0; op_code = 3'd0;
      #1;
    end
    chk({tag, "_stall"}, 64'(n), 64'(exp_stall));
    tick();
    op_valid = 1'b0; op_code = 3'd0;
    chk({tag, "_hilo"}, {hi, lo}, sb_q.pop_front());
  endtask

  initial begin
    bit saw;
    int k;
    #12;
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_ctl", {62'd0, stallreq, busy}, 64'd0);
    chk("rst_ops", {div_start, div_signed, mul_signed, mul_a, 29'd0}, 64'd0);
    resetn = 1'b1;
    tick();

    run_op("mult", 3'(OP_MULT), 32'hFFFFFFFE, 32'd3, 2, 64'hFFFFFFFF_FFFFFFFA, saw);
    tick();

    run_op("divu", 3'(OP_DIVU), 32'd100, 32'd7, DIV_DELAY + 1, {32'd2, 32'd14}, saw);
    chk("divu_start_seen", 64'(saw), 64'd1);
    chk("divu_start_drop", 64'(div_start), 64'd0);
    tick();

    // Back-to-back MTHI/MTLO in consecutive cycles.
    sb_q.push_back({32'h12345678, 32'd14});
    sb_q.push_back({32'h12345678, 32'h9ABCDEF0});
    op_valid = 1'b1; op_code = 3'(OP_MTHI); src_a = 32'h12345678; #1;
    chk("mthi_stall", 64'(stallreq), 64'd0);
    tick();
    op_code = 3'(OP_MTLO); src_a = 32'h9ABCDEF0; #1;
    chk("mtlo_stall", 64'(stallreq), 64'd0);
    chk("mthi_hilo", {hi, lo}, sb_q.pop_front());
    tick();
    op_valid = 1'b0; op_code = 3'd0;
    chk("mtlo_hilo", {hi, lo}, sb_q.pop_front());

    // Annul ten cycles into a signed divide.
    sb_q.push_back({32'h12345678, 32'h9ABCDEF0});
    op_valid = 1'b1; op_code = 3'(OP_DIV); src_a = 32'hFFFFFF9C; src_b = 32'd7;
    tick();
    op_valid = 1'b0; op_code = 3'd0;
    repeat (9) tick();
    annul = 1'b1; #1;
    chk("annul_pulse", 64'(div_annul), 64'd1);
    chk("annul_stall", 64'(stallreq), 64'd0);
    tick();
    annul = 1'b0; #1;
    chk("annul_pulse_end", {62'd0, div_annul, div_start}, 64'd0);
    chk("annul_idle", 64'(busy), 64'd0);
    repeat (40) tick();
    chk("annul_hilo", {hi, lo}, sb_q.pop_front());

    // Annul coinciding with div_ready: annul wins, no write.
    sb_q.push_back({32'h12345678, 32'h9ABCDEF0});
    op_valid = 1'b1; op_code = 3'(OP_DIVU); src_a = 32'd50; src_b = 32'd5;
    tick();
    op_valid = 1'b0; op_code = 3'd0;
    k = 0;
    while (!div_ready && k < 100) begin
      k++;
      tick();
    end
    chk("coinc_ready_seen", 64'(div_ready), 64'd1);
    annul = 1'b1; #1;
    chk("coinc_stall", 64'(stallreq), 64'd0);
    chk("coinc_annul", 64'(div_annul), 64'd1);
    tick();
    annul = 1'b0;
    chk("coinc_hilo", {hi, lo}, sb_q.pop_front());
    chk("coinc_idle", 64'(busy), 64'd0);
    tick();

    // MULTU finishing while EX stays stalled: DONE is held, no re-issue.
    ex_advance = 1'b0;
    run_op("multu", 3'(OP_MULTU), 32'hFFFFFFFF, 32'd2, 2, {32'd1, 32'hFFFFFFFE}, saw);
    op_valid = 1'b1; op_code = 3'(OP_MULTU); src_a = 32'd3; src_b = 32'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("held_stall", 64'(stallreq), 64'd0);
      chk("held_busy", 64'(busy), 64'd1);
      tick();
    end
    ex_advance = 1'b1;
    tick();
    op_valid = 1'b0; op_code = 3'd0; #1;
    chk("held_idle", 64'(busy), 64'd0);
    chk("held_hilo", {hi, lo}, {32'd1, 32'hFFFFFFFE});
    tick();

    // Asynchronous reset while in MUL_WAIT.
    op_valid = 1'b1; op_code = 3'(OP_MULT); src_a = 32'd5; src_b = 32'd6; #1;
    tick();
    op_valid = 1'b0; op_code = 3'd0; #1;
    chk("rstmid_inwait", 64'(busy), 64'd1);
    #1 resetn = 1'b0;
    #1;
    chk("rstmid_hilo", {hi, lo}, 64'd0);
    chk("rstmid_ctl", {60'd0, stallreq, busy, div_start, mul_signed}, 64'd0);
    chk("rstmid_ops", {mul_a, mul_b}, 64'd0);
    #2 resetn = 1'b1;
    tick();
    #1;
    chk("rstmid_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the bench always reaches its summary.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: got running expected finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
